// File: rtl/datamover_pkg.sv
`default_nettype none
// datamover_pkg: 72-bit read-command layout and FSM state encoding for datamover_rd_mb.
// Rev 1.0
package datamover_pkg;

  localparam int CMD_W    = 72;
  localparam int TAG_W    = 4;
  localparam int ADDR_W   = 32;
  localparam int BTT_W    = 23;
  localparam int TAG_LSB  = 64;
  localparam int ADDR_LSB = 32;
  localparam int EOF_BIT  = 30;
  localparam int INCR_BIT = 23;

  localparam logic CMD_EOF  = 1'b1;
  localparam logic CMD_INCR = 1'b1;

  typedef struct packed {
    logic [3:0]        rsvd;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] saddr;
    logic              drr;
    logic              eof;
    logic [5:0]        dsa;
    logic              incr;
    logic [BTT_W-1:0]  btt;
  } rd_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } dm_state_t;

  function automatic rd_cmd_t make_cmd(input logic [TAG_W-1:0]  tag,
                                       input logic [ADDR_W-1:0] addr,
                                       input logic [BTT_W-1:0]  btt);
    rd_cmd_t c;
    c       = '0;
    c.tag   = tag;
    c.saddr = addr;
    c.eof   = CMD_EOF;
    c.incr  = CMD_INCR;
    c.btt   = btt;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/datamover_rd_mb.sv
`default_nettype none
// datamover_rd_mb: splits a read transfer into MAX_BTT commands with bounded outstanding count.
// Rev 1.0
module datamover_rd_mb
  import datamover_pkg::*;
#(
  parameter int DATA_W          = 64,
  parameter int MAX_BTT         = 4096,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_length,
  input  logic [31:0]         i_start_addr,
  output logic                o_busy,
  output logic                o_done,
  output logic [31:0]         o_rx_bytes,
  input  logic                i_mm2s_rd_cmd_tready,
  output logic [CMD_W-1:0]    o_mm2s_rd_cmd_tdata,
  output logic                o_mm2s_rd_cmd_tvalid,
  input  logic [DATA_W-1:0]   i_mm2s_rd_tdata,
  input  logic [DATA_W/8-1:0] i_mm2s_rd_tkeep,
  input  logic                i_mm2s_rd_tvalid,
  input  logic                i_mm2s_rd_tlast,
  output logic                o_mm2s_rd_tready,
  output logic [DATA_W-1:0]   o_m_axis_tdata,
  output logic [DATA_W/8-1:0] o_m_axis_tkeep,
  output logic                o_m_axis_tvalid,
  output logic                o_m_axis_tlast,
  input  logic                i_m_axis_tready
);

  localparam int                KEEP_W    = DATA_W / 8;
  localparam logic [TAG_W-1:0]  MAX_OUT   = TAG_W'(MAX_OUTSTANDING);
  localparam logic [LEN_W-1:0]  MAX_BTT_L = LEN_W'(MAX_BTT);

  dm_state_t          state_q, state_d;
  logic               start_d_q, start_p_q;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d, rem_after;
  logic [TAG_W-1:0]   tag_q, tag_d, outst_q, outst_d;
  logic [31:0]        rx_q, rx_d, keep_cnt;
  logic [BTT_W-1:0]   btt;
  logic               cmd_acc, beat_acc, last_acc;

  assign o_m_axis_tdata   = i_mm2s_rd_tdata;
  assign o_m_axis_tkeep   = i_mm2s_rd_tkeep;
  assign o_m_axis_tvalid  = i_mm2s_rd_tvalid;
  assign o_m_axis_tlast   = i_mm2s_rd_tlast;
  assign o_mm2s_rd_tready = i_m_axis_tready;

  assign beat_acc  = i_mm2s_rd_tvalid & i_m_axis_tready;
  assign last_acc  = beat_acc & i_mm2s_rd_tlast;
  assign cmd_acc   = (state_q == ST_CMD) & i_mm2s_rd_cmd_tready;
  assign btt       = (rem_q > MAX_BTT_L) ? BTT_W'(MAX_BTT) : BTT_W'(rem_q);
  assign rem_after = rem_q - LEN_W'(btt);

  assign o_busy               = (state_q != ST_IDLE);
  assign o_done               = (state_q == ST_DONE);
  assign o_rx_bytes           = rx_q;
  assign o_mm2s_rd_cmd_tvalid = (state_q == ST_CMD);
  assign o_mm2s_rd_cmd_tdata  = (state_q == ST_CMD) ? make_cmd(tag_q, addr_q, btt) : '0;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      keep_cnt = keep_cnt + 32'(i_mm2s_rd_tkeep[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    tag_d   = tag_q;
    rx_d    = rx_q;
    outst_d = outst_q;

    // A command accepted in the same cycle as a tlast leaves the count unchanged.
    if (cmd_acc && !last_acc) begin
      outst_d = outst_q + 1'b1;
    end else if (!cmd_acc && last_acc && (outst_q != '0)) begin
      outst_d = outst_q - 1'b1;
    end

    if ((state_q != ST_IDLE) && beat_acc) begin
      rx_d = rx_q + keep_cnt;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_p_q) begin
          addr_d  = i_start_addr;
          rem_d   = i_length;
          tag_d   = '0;
          outst_d = '0;
          rx_d    = '0;
          state_d = (i_length != '0) ? ST_CMD : ST_DONE;
        end
      end
      ST_CMD: begin
        if (cmd_acc) begin
          addr_d = addr_q + 32'(btt);
          rem_d  = rem_after;
          tag_d  = tag_q + 1'b1;
          if (rem_after == '0) begin
            state_d = ST_DRAIN;
          end else if (outst_d == MAX_OUT) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (outst_d < MAX_OUT) begin
          state_d = ST_CMD;
        end
      end
      ST_DRAIN: begin
        if (outst_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      start_d_q <= 1'b0;
      start_p_q <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      tag_q     <= '0;
      outst_q   <= '0;
      rx_q      <= '0;
    end else begin
      state_q   <= state_d;
      start_d_q <= i_start;
      start_p_q <= i_start & ~start_d_q;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      tag_q     <= tag_d;
      outst_q   <= outst_d;
      rx_q      <= rx_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/datamover_rd_mb.md
DATAMOVER_RD_MB -- requirements
Module: datamover_rd_mb

Interface
REQ-001 Parameter DATA_W, default 64, stream data width in bits (multiple of 8).
REQ-002 Parameter MAX_BTT, default 4096, max bytes per command (power of two, <= 2^22).
REQ-003 Parameter MAX_OUTSTANDING, default 4, max issued commands without a received tlast (1..15).
REQ-004 Parameter LEN_W, default 32, transfer length width in bytes.
REQ-005 Ports SHALL be exactly:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  level; rising edge starts a transfer
- i_length  in  LEN_W  total bytes
- i_start_addr  in  32  byte start address
- o_busy  out  1  high while not IDLE
- o_done  out  1  one-cycle completion pulse
- o_rx_bytes  out  32  bytes received in current/last transfer
- i_mm2s_rd_cmd_tready  in  1  command accept
- o_mm2s_rd_cmd_tdata  out  72  command word
- o_mm2s_rd_cmd_tvalid  out  1  command valid
- i_mm2s_rd_tdata  in  DATA_W  read data
- i_mm2s_rd_tkeep  in  DATA_W/8  byte enables
- i_mm2s_rd_tvalid, i_mm2s_rd_tlast  in  1  data valid / end of command
- o_mm2s_rd_tready  out  1  data ready
- o_m_axis_tdata/tkeep/tvalid/tlast  out  DATA_W, DATA_W/8, 1, 1  forwarded stream
- i_m_axis_tready  in  1  downstream ready

Function
REQ-006 Start edge SHALL be registered: start_p = i_start & ~i_start_d, acted on one cycle after i_start rises; edges outside IDLE are ignored.
REQ-007 States: IDLE, CMD, WAIT, DRAIN, DONE.
REQ-008 IDLE: on start_p latch address, remaining=i_length, tag=0, outstanding=0, o_rx_bytes=0; go CMD if i_length>0, else DONE.
REQ-009 CMD: tvalid=1; tdata held stable until tready; BTT=min(remaining, MAX_BTT).
REQ-010 Command word: [71:68]=0, [67:64]=tag, [63:32]=address, [31]=0, [30]=1 (EOF), [29:24]=0, [23]=1 (INCR), [22:0]=BTT.
REQ-011 On accept: address+=BTT (mod 2^32), remaining-=BTT, tag+=1 (wraps 15->0), outstanding+=1.
REQ-012 After accept: remaining==0 -> DRAIN; else outstanding==MAX_OUTSTANDING -> WAIT; else stay CMD.
REQ-013 WAIT: tvalid=0; go CMD when outstanding<MAX_OUTSTANDING.
REQ-014 Beat accepted when i_mm2s_rd_tvalid & o_mm2s_rd_tready; with tlast it decrements outstanding; simultaneous accept and tlast SHALL net zero; outstanding never underflows (stray tlast at 0 ignored).
REQ-015 DRAIN: go DONE when outstanding==0; DONE asserts o_done one cycle, then IDLE.
REQ-016 Data path combinational pass-through: o_m_axis_* = i_mm2s_rd_*, o_mm2s_rd_tready = i_m_axis_tready.
REQ-017 o_rx_bytes SHALL add popcount(tkeep) per accepted beat, 32-bit wrap, held after DONE until next start.
REQ-018 Outside CMD, o_mm2s_rd_cmd_tdata SHALL be 0.

Reset
REQ-019 rst SHALL force IDLE and clear start_d, outstanding, tag, address, remaining, o_rx_bytes, o_done, o_busy, o_mm2s_rd_cmd_tvalid to 0, taking effect mid-transfer with no further commands issued.

Structure
REQ-020 Shared package datamover_pkg SHALL hold the command field positions/widths, EOF/INCR constants and a packed struct typedef for the 72-bit command.
REQ-021 Single module; no sub-module required.

Verification
REQ-022 Length 1000, addr 0x1000_0000 -> one command BTT=1000, tag 0, EOF=1; 125 beats of 64-bit data forwarded; o_rx_bytes=1000; o_done once.
REQ-023 Length 10000, MAX_BTT 4096 -> three commands BTT 4096/4096/1808 at 0x0, 0x1000, 0x2000, tags 0,1,2.
REQ-024 MAX_OUTSTANDING 2, length 16384, no tlast returned -> exactly 2 commands, then tvalid low (WAIT); one tlast -> third command issued next cycle.
REQ-025 Length 0 -> no command, o_done pulses two cycles after i_start rises.
REQ-026 cmd_tready low for 5 cycles -> tdata/tvalid stable; i_start re-pulsed while busy -> ignored; rst mid-DRAIN -> all outputs 0, IDLE next cycle.
